// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multicycle MIPS control path: opcode values,
// ALUOp / PCSource / ALUSrcB select codes, the main-FSM state encoding and
// the packed control-output bundle that the output decoder produces.
package mips_pkg;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes consumed by ALUControl (11 is never driven)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PCSource selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Main FSM states; codes 13-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;

    // Every datapath enable/select driven by the control FSM
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // True for the opcodes this datapath knows how to execute
    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/control_outdec.sv
// control_outdec
// Purely combinational Moore output decoder for the multicycle control FSM.
// Ports:
//   state     in  current FSM state
//   mem_ready in  memory handshake (only used for IRWrite/PCWrite in FETCH)
//   ctrl      out full control-output bundle; anything not set is 0
module control_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Per-state output table. FETCH is the only state whose outputs depend
    // on an input: the IR and PC are loaded on the edge the fetch completes.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for the multicycle MIPS datapath: sequences each
// instruction through fetch/decode/execute/memory/write-back.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Op                    opcode IR[31:26], looked at only in DECODE
//   MemReady              memory handshake, access completes when 1
//   PCWrite..ALUSrcA      1-bit datapath enables/selects
//   PCSource, ALUSrcB     2-bit mux selects
//   ALUOp                 2-bit op class for ALUControl
//   IllegalOp             sticky unsupported-opcode flag
//   InstrCount            completed-fetch counter (wraps)
//   State                 current state code, for debug
module multicycle_control
    import mips_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               IllegalOp,
    output logic [COUNT_W-1:0] InstrCount,
    output logic [3:0]         State
);

    state_t               state;
    state_t               next_state;
    ctrl_t                ctrl;
    logic                 is_store;
    logic                 illegal_q;
    logic [COUNT_W-1:0]   count_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. lw/sw share MEMADR; the store/load choice made in
    // DECODE is remembered in is_store so Op is never re-read afterwards.
    always_comb begin
        next_state = FETCH;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH:  next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: next_state = is_store ? MEMWR : MEMRD;
            MEMRD:  next_state = MemReady ? MEMWB : MEMRD;
            MEMWB:  next_state = FETCH;
            MEMWR:  next_state = MemReady ? FETCH : MEMWR;
            EXEC:   next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            JUMP:   next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Retired-fetch counter, sticky illegal-opcode flag and the latched
    // load/store direction. All captured on clock edges only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            illegal_q <= 1'b0;
            is_store  <= 1'b0;
        end else begin
            if (state == FETCH && MemReady) begin
                count_q <= count_q + COUNT_W'(1);
            end
            if (state == DECODE) begin
                is_store <= (Op == OP_SW);
                if (!is_supported_op(Op)) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    // Output logic: Moore decode of the state register
    control_outdec u_outdec (
        .state     (state),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.memto_reg;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign IllegalOp   = illegal_q;
    assign InstrCount  = count_q;
    assign State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Self-checking bench for multicycle_control. A reference model expands each
// instruction class into its expected sequence of states and checks every
// cycle's state, control outputs, fetch counter and sticky illegal flag.
// The counter is instantiated narrow so that wrap-around is exercised.
module tb_multicycle_control;

    localparam int CW = 4;

    // State codes and opcodes as listed for the debug port / ISA
    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5;
    localparam logic [3:0] S_MEMWR = 4'd6, S_EXEC = 4'd7,   S_ALUWB = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9, S_JUMP = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11, S_ADDIWB = 4'd12;

    localparam logic [5:0] K_RTYPE = 6'b000000, K_LW = 6'b100011, K_SW = 6'b101011;
    localparam logic [5:0] K_BEQ = 6'b000100, K_J = 6'b000010, K_ADDI = 6'b001000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [5:0]     Op;
    logic           MemReady;
    logic           PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic           MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]     PCSource, ALUSrcB, ALUOp;
    logic           IllegalOp;
    logic [CW-1:0]  InstrCount;
    logic [3:0]     State;

    int             checks = 0;
    int             errors = 0;
    int             instrNo = 0;
    logic [CW-1:0]  expCount;
    logic           expIll;

    always #5 clk = ~clk;

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .IllegalOp   (IllegalOp),
        .InstrCount  (InstrCount),
        .State       (State)
    );

    wire [15:0] obsCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                           MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp};

    function automatic logic isLegal(input logic [5:0] op);
        return op inside {K_RTYPE, K_LW, K_SW, K_BEQ, K_J, K_ADDI};
    endfunction

    // Required control outputs for a state, straight from the per-state table
    function automatic logic [15:0] expOut(input logic [3:0] st, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, sa;
        logic [1:0] pcs, sb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, sa} = '0;
        pcs = 2'b00; sb = 2'b00; aop = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE: begin sb = 2'b11; end
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iord = 1; end
            S_EXEC:   begin sa = 1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1; rdst = 1; end
            S_BRANCH: begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            S_JUMP:   begin pcw = 1; pcs = 2'b10; end
            S_ADDIEX: begin sa = 1; sb = 2'b10; end
            S_ADDIWB: begin rw = 1; end
            default:  ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, sa, pcs, sb, aop};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s instr=%0d observed=%0h expected=%0h",
                   tag, instrNo, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [5:0] op);
        MemReady = mr;
        Op       = op;
    endtask

    // One clock cycle: drive inputs after the falling edge, check shortly
    // after, then advance the model across the rising edge.
    task automatic stepCycle(input logic [3:0] st, input logic mr, input logic [5:0] op);
        applyStimulus(mr, op);
        #1;
        checkOutput("state",   32'(State),      32'(st));
        checkOutput("ctrl",    32'(obsCtrl),    32'(expOut(st, mr)));
        checkOutput("count",   32'(InstrCount), 32'(expCount));
        checkOutput("illegal", 32'(IllegalOp),  32'(expIll));
        @(posedge clk);
        if (st == S_FETCH && mr) expCount = expCount + 1'b1;
        if (st == S_DECODE && !isLegal(op)) expIll = 1'b1;
        @(negedge clk);
    endtask

    // Expand one instruction into its expected state sequence.
    // wf = wait cycles in FETCH, wm = wait cycles in MEMRD/MEMWR.
    task automatic runInstr(input logic [5:0] op, input int wf, input int wm);
        instrNo++;
        for (int i = 0; i < wf; i++) stepCycle(S_FETCH, 1'b0, 6'($urandom));
        stepCycle(S_FETCH, 1'b1, 6'($urandom));
        stepCycle(S_DECODE, 1'($urandom), op);
        case (op)
            K_LW: begin
                stepCycle(S_MEMADR, 1'($urandom), op);
                for (int i = 0; i < wm; i++) stepCycle(S_MEMRD, 1'b0, op);
                stepCycle(S_MEMRD, 1'b1, op);
                stepCycle(S_MEMWB, 1'($urandom), op);
            end
            K_SW: begin
                stepCycle(S_MEMADR, 1'($urandom), op);
                for (int i = 0; i < wm; i++) stepCycle(S_MEMWR, 1'b0, op);
                stepCycle(S_MEMWR, 1'b1, op);
            end
            K_RTYPE: begin
                stepCycle(S_EXEC, 1'($urandom), op);
                stepCycle(S_ALUWB, 1'($urandom), op);
            end
            K_BEQ:   stepCycle(S_BRANCH, 1'($urandom), op);
            K_J:     stepCycle(S_JUMP, 1'($urandom), op);
            K_ADDI: begin
                stepCycle(S_ADDIEX, 1'($urandom), op);
                stepCycle(S_ADDIWB, 1'($urandom), op);
            end
            default: ;
        endcase
        checkOutput("next_fetch", 32'(State), 32'(S_FETCH));
    endtask

    initial begin
        logic [5:0] rop;
        int         idx;

        // Reset with MemReady high: everything quiet before any clock edge
        rst_n = 1'b0;
        expCount = '0;
        expIll = 1'b0;
        applyStimulus(1'b1, 6'b0);
        #3;
        checkOutput("rst_state",   32'(State),      32'(S_IDLE));
        checkOutput("rst_ctrl",    32'(obsCtrl),    32'(0));
        checkOutput("rst_count",   32'(InstrCount), 32'(0));
        checkOutput("rst_illegal", 32'(IllegalOp),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle(S_IDLE, 1'b1, 6'b0);

        // Directed instructions
        runInstr(K_RTYPE, 0, 0);
        runInstr(K_LW, 0, 2);
        runInstr(K_BEQ, 0, 0);
        runInstr(6'b111111, 0, 0);
        runInstr(K_RTYPE, 1, 0);

        // Randomized instruction stream; counter wraps past 2^CW fetches
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 6));
            case (idx)
                0: rop = K_LW;
                1: rop = K_SW;
                2: rop = K_RTYPE;
                3: rop = K_BEQ;
                4: rop = K_J;
                5: rop = K_ADDI;
                default: begin
                    do rop = 6'($urandom); while (isLegal(rop));
                end
            endcase
            runInstr(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // Store interrupted by reset while waiting in MEMWR
        instrNo++;
        stepCycle(S_FETCH, 1'b1, K_SW);
        stepCycle(S_DECODE, 1'b1, K_SW);
        stepCycle(S_MEMADR, 1'b1, K_SW);
        applyStimulus(1'b0, K_SW);
        #1;
        checkOutput("memwr_state", 32'(State),    32'(S_MEMWR));
        checkOutput("memwr_write", 32'(MemWrite), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        expCount = '0;
        expIll = 1'b0;
        checkOutput("abort_write",   32'(MemWrite),   32'(0));
        checkOutput("abort_state",   32'(State),      32'(S_IDLE));
        checkOutput("abort_count",   32'(InstrCount), 32'(0));
        checkOutput("abort_illegal", 32'(IllegalOp),  32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle(S_IDLE, 1'b1, 6'b0);
        runInstr(K_ADDI, 0, 0);
        runInstr(K_J, 2, 0);
        runInstr(K_SW, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
